// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for the five-stage pipeline, sitting beside the ID stage.
// It covers three cases: load-use stalls of configurable length, multi-cycle
// mul/div occupancy of EX, and data-memory wait states, which freeze the
// whole pipe. It also flushes the pipe on taken branches.
//
// Outputs are Mealy. They come from the registered state and the current
// inputs, so the first stall cycle has no added latency.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   rs1_ifr_i      : rs1 of the IF/ID instruction
//   rs2_ifr_i      : rs2 of the IF/ID instruction
//   rs1_used_i     : IF/ID instruction reads rs1
//   rs2_used_i     : IF/ID instruction reads rs2
//   rd_idr_i       : rd of the ID/EX instruction
//   MemRead_idr_i  : ID/EX instruction is a load
//   md_start_idr_i : ID/EX instruction is a mul/div entering EX
//   mem_wait_i     : data memory not ready, freeze everything
//   branch_taken_i : taken branch/jump resolved in EX
//   stall_pc_o     : hold the PC
//   nop_o          : bubble into ID/EX
//   nop_ex_o       : bubble into EX/MEM
//   stall_r_o      : per pipeline-register hold (bit0 IF/ID ... bit3 MEM/WB)
//   flush_o        : squash IF/ID and ID/EX
//   busy_o         : registered state is a stall state
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int N_REGS   = 4,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_W-1:0]  rs1_ifr_i,
  input  logic [REG_W-1:0]  rs2_ifr_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [REG_W-1:0]  rd_idr_i,
  input  logic              MemRead_idr_i,
  input  logic              md_start_idr_i,
  input  logic              mem_wait_i,
  input  logic              branch_taken_i,
  output logic              stall_pc_o,
  output logic              nop_o,
  output logic              nop_ex_o,
  output logic [N_REGS-1:0] stall_r_o,
  output logic              flush_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LU   = 2'd1,
    ST_MD   = 2'd2
  } state_e;

  // The detection cycle is the first stall cycle. A stall state is only
  // needed when the stall lasts longer than that single cycle.
  localparam bit LU_MULTI = (LOAD_LAT > 1);
  localparam bit MD_MULTI = (MD_LAT > 2);
  localparam int LU_INIT_I = LU_MULTI ? (LOAD_LAT - 2) : 0;
  localparam int MD_INIT_I = MD_MULTI ? (MD_LAT - 3) : 0;
  localparam logic [3:0] LU_INIT = LU_INIT_I[3:0];
  localparam logic [3:0] MD_INIT = MD_INIT_I[3:0];

  localparam logic [N_REGS-1:0] LU_HOLD     = N_REGS'(1);
  localparam logic [N_REGS-1:0] MD_HOLD     = N_REGS'(3);
  localparam logic [N_REGS-1:0] FREEZE_HOLD = {N_REGS{1'b1}};

  state_e     state_r;
  state_e     state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic       lu_s;

  // Load-use hazard. An rd of x0 never creates a dependency, and an operand
  // that is not read is ignored.
  always_comb begin
    lu_s = MemRead_idr_i && (rd_idr_i != '0) &&
           ((rs1_used_i && (rd_idr_i == rs1_ifr_i)) ||
            (rs2_used_i && (rd_idr_i == rs2_ifr_i)));
  end

  // Priority chain: memory freeze, then an active stall, then flush,
  // then mul/div start, then load-use.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_pc_o  = 1'b0;
    nop_o       = 1'b0;
    nop_ex_o    = 1'b0;
    stall_r_o   = '0;
    flush_o     = 1'b0;
    busy_o      = 1'b0;
    if (!rst_ni) begin
      // Reset forces quiet outputs, including while reset is still asserted.
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 4'd0;
    end else begin
      busy_o = (state_r != ST_IDLE);
      if (mem_wait_i) begin
        // State and counter hold. Detection is retried after the wait.
        stall_pc_o = 1'b1;
        stall_r_o  = FREEZE_HOLD;
      end else begin
        case (state_r)
          ST_LU: begin
            stall_pc_o = 1'b1;
            nop_o      = 1'b1;
            stall_r_o  = LU_HOLD;
            if (cnt_r == 4'd0) begin
              state_nxt_s = ST_IDLE;
            end else begin
              cnt_nxt_s = cnt_r - 4'd1;
            end
          end
          ST_MD: begin
            stall_pc_o = 1'b1;
            nop_ex_o   = 1'b1;
            stall_r_o  = MD_HOLD;
            if (cnt_r == 4'd0) begin
              state_nxt_s = ST_IDLE;
            end else begin
              cnt_nxt_s = cnt_r - 4'd1;
            end
          end
          ST_IDLE: begin
            if (branch_taken_i) begin
              flush_o = 1'b1;
            end else if (md_start_idr_i) begin
              stall_pc_o = 1'b1;
              nop_ex_o   = 1'b1;
              stall_r_o  = MD_HOLD;
              if (MD_MULTI) begin
                state_nxt_s = ST_MD;
                cnt_nxt_s   = MD_INIT;
              end else begin
                state_nxt_s = ST_IDLE;
              end
            end else if (lu_s) begin
              stall_pc_o = 1'b1;
              nop_o      = 1'b1;
              stall_r_o  = LU_HOLD;
              if (LU_MULTI) begin
                state_nxt_s = ST_LU;
                cnt_nxt_s   = LU_INIT;
              end else begin
                state_nxt_s = ST_IDLE;
              end
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end
          default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
          end
        endcase
      end
    end
  end

  // State and stall counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Drives two hazard_ctrl instances from the same inputs.
//   a: LOAD_LAT=1, MD_LAT=4
//   b: LOAD_LAT=3, MD_LAT=8
// Most checks come from a table of per-cycle vectors. A short hand-written
// sequence covers reset asserted in the middle of a stall.
// Output packing for the table: {stall_pc, nop, nop_ex, flush, busy, stall_r[3:0]}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, md, mw, br;

  logic       pc_a, nop_a, nopex_a, fl_a, busy_a;
  logic [3:0] sr_a;
  logic       pc_b, nop_b, nopex_b, fl_b, busy_b;
  logic [3:0] sr_b;

  hazard_ctrl #(.REG_W(5), .N_REGS(4), .LOAD_LAT(1), .MD_LAT(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_ifr_i(rs1), .rs2_ifr_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
    .rd_idr_i(rd), .MemRead_idr_i(mr), .md_start_idr_i(md),
    .mem_wait_i(mw), .branch_taken_i(br),
    .stall_pc_o(pc_a), .nop_o(nop_a), .nop_ex_o(nopex_a),
    .stall_r_o(sr_a), .flush_o(fl_a), .busy_o(busy_a)
  );

  hazard_ctrl #(.REG_W(5), .N_REGS(4), .LOAD_LAT(3), .MD_LAT(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_ifr_i(rs1), .rs2_ifr_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
    .rd_idr_i(rd), .MemRead_idr_i(mr), .md_start_idr_i(md),
    .mem_wait_i(mw), .branch_taken_i(br),
    .stall_pc_o(pc_b), .nop_o(nop_b), .nop_ex_o(nopex_b),
    .stall_r_o(sr_b), .flush_o(fl_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output patterns.
  localparam logic [8:0] O   = 9'b0_0_0_0_0_0000;
  localparam logic [8:0] LU0 = 9'b1_1_0_0_0_0001;
  localparam logic [8:0] LU1 = 9'b1_1_0_0_1_0001;
  localparam logic [8:0] MD0 = 9'b1_0_1_0_0_0011;
  localparam logic [8:0] MD1 = 9'b1_0_1_0_1_0011;
  localparam logic [8:0] FZ0 = 9'b1_0_0_0_0_1111;
  localparam logic [8:0] FZ1 = 9'b1_0_0_0_1_1111;
  localparam logic [8:0] FL  = 9'b0_0_0_1_0_0000;

  typedef struct {
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, mr, md, mw, br;
    logic [8:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(input logic [4:0] v_rd, input logic [4:0] v_rs1,
                              input logic [4:0] v_rs2, input logic v_u1,
                              input logic v_u2, input logic v_mr,
                              input logic v_md, input logic v_mw,
                              input logic v_br, input logic [8:0] ea,
                              input logic [8:0] eb);
    vec_t v;
    v.rd = v_rd; v.rs1 = v_rs1; v.rs2 = v_rs2;
    v.u1 = v_u1; v.u2 = v_u2; v.mr = v_mr;
    v.md = v_md; v.mw = v_mw; v.br = v_br;
    v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  // Shorthands for the two common input patterns.
  function automatic vec_t idle(input logic v_mw, input logic v_br,
                                input logic [8:0] ea, input logic [8:0] eb);
    return mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, v_mw, v_br, ea, eb);
  endfunction

  function automatic vec_t lu(input logic v_mw, input logic v_br,
                              input logic [8:0] ea, input logic [8:0] eb);
    return mk(5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, v_mw, v_br, ea, eb);
  endfunction

  task automatic apply(input vec_t v);
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    u1 = v.u1; u2 = v.u2; mr = v.mr;
    md = v.md; mw = v.mw; br = v.br;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%b expected=%b", name, idx, got, exp);
    end
  endtask

  function automatic logic [8:0] out_a();
    return {pc_a, nop_a, nopex_a, fl_a, busy_a, sr_a};
  endfunction

  function automatic logic [8:0] out_b();
    return {pc_b, nop_b, nopex_b, fl_b, busy_b, sr_b};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    // Load-use on rs1, then the same inputs with rs1 unused, then with rd=x0.
    vecs.push_back(idle(1'b0, 1'b0, O, O));
    vecs.push_back(mk(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, LU0, LU0));
    vecs.push_back(idle(1'b0, 1'b0, O, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, O));
    vecs.push_back(mk(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O, O));
    vecs.push_back(mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O, O));
    // Load-use on rs2.
    vecs.push_back(lu(1'b0, 1'b0, LU0, LU0));
    vecs.push_back(idle(1'b0, 1'b0, O, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, O));
    // Mul/div: a stalls 3 cycles, b stalls 7 cycles.
    vecs.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MD0, MD0));
    vecs.push_back(idle(1'b0, 1'b0, MD1, MD1));
    vecs.push_back(idle(1'b0, 1'b0, MD1, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, O));
    // Two cycles of mem_wait during b's load-use stall stretch it to 5 cycles.
    vecs.push_back(lu(1'b0, 1'b0, LU0, LU0));
    vecs.push_back(idle(1'b1, 1'b0, FZ0, FZ1));
    vecs.push_back(idle(1'b1, 1'b0, FZ0, FZ1));
    vecs.push_back(idle(1'b0, 1'b0, O, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, O));
    // mem_wait in IDLE hides the load-use; it is detected after the wait.
    vecs.push_back(lu(1'b1, 1'b0, FZ0, FZ0));
    vecs.push_back(lu(1'b0, 1'b0, LU0, LU0));
    vecs.push_back(idle(1'b0, 1'b0, O, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, O));
    // A taken branch wins over load-use and mul/div start.
    vecs.push_back(lu(1'b0, 1'b1, FL, FL));
    vecs.push_back(idle(1'b0, 1'b0, O, O));
    vecs.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FL, FL));
    vecs.push_back(idle(1'b0, 1'b0, O, O));
    // md_start wins over load-use in the same cycle.
    vecs.push_back(mk(5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, MD0, MD0));
    vecs.push_back(idle(1'b0, 1'b0, MD1, MD1));
    vecs.push_back(idle(1'b0, 1'b0, MD1, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, MD1));
    vecs.push_back(idle(1'b0, 1'b0, O, O));
    // A branch during a stall state gives no flush: the stall has priority.
    vecs.push_back(lu(1'b0, 1'b0, LU0, LU0));
    vecs.push_back(idle(1'b0, 1'b1, FL, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, LU1));
    vecs.push_back(idle(1'b0, 1'b0, O, O));

    // Reset state, with mem_wait high to show reset wins.
    rst_n = 1'b0;
    apply(idle(1'b1, 1'b0, O, O));
    #3;
    check("reset_a", 0, out_a(), O);
    check("reset_b", 0, out_b(), O);
    @(negedge clk);
    rst_n = 1'b1;
    mw    = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(negedge clk);
      check("vec_a", i, out_a(), vecs[i].exp_a);
      check("vec_b", i, out_b(), vecs[i].exp_b);
      @(posedge clk);
      #1;
    end

    // b reaches MD_BUSY cycle 2, then reset is pulled mid-cycle.
    apply(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O, O));
    @(negedge clk);
    check("rst_md_start_b", 0, out_b(), MD0);
    @(posedge clk); #1;
    apply(idle(1'b0, 1'b0, O, O));
    @(negedge clk);
    check("rst_md_c1_b", 0, out_b(), MD1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_md_c2_b", 0, out_b(), MD1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_a", 0, out_a(), O);
    check("rst_mid_b", 0, out_b(), O);
    @(posedge clk); #1;
    check("rst_hold_b", 0, out_b(), O);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_b", 0, out_b(), O);
    @(posedge clk); #1;
    // A fresh load-use after reset.
    apply(mk(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O, O));
    @(negedge clk);
    check("post_rst_lu_a", 0, out_a(), LU0);
    check("post_rst_lu_b", 0, out_b(), LU0);
    @(posedge clk); #1;
    apply(idle(1'b0, 1'b0, O, O));
    @(negedge clk);
    check("post_rst_lu_a", 1, out_a(), O);
    check("post_rst_lu_b", 1, out_b(), LU1);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_lu_b", 2, out_b(), LU1);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_lu_b", 3, out_b(), O);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the five-stage pipeline. It generalises load-use detection in three ways: stalls last a configurable number of cycles, source operands that are not read are ignored, and it handles multi-cycle mul/div occupancy, data-memory wait states and taken-branch flushes. It sits beside the ID stage and drives the PC enable, the per-register hold vector, the bubble inserts and the flush line.

## Interface

Parameters:
- REG_W, 5: register-index width.
- N_REGS, 4: number of pipeline registers held by stall_r_o. Bit 0 = IF/ID, bit 1 = ID/EX, bit 2 = EX/MEM, bit 3 = MEM/WB. Minimum 2.
- LOAD_LAT, 1: load-use stall length in cycles. Range 1..15.
- MD_LAT, 4: mul/div execute latency in cycles. Range 2..16.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_ni, in, 1: asynchronous active-low reset.
- rs1_ifr_i, in, REG_W: rs1 of the instruction in IF/ID.
- rs2_ifr_i, in, REG_W: rs2 of the instruction in IF/ID.
- rs1_used_i, in, 1: the IF/ID instruction reads rs1.
- rs2_used_i, in, 1: the IF/ID instruction reads rs2.
- rd_idr_i, in, REG_W: rd of the instruction in ID/EX.
- MemRead_idr_i, in, 1: the ID/EX instruction is a load.
- md_start_idr_i, in, 1: the ID/EX instruction is a mul/div entering EX.
- mem_wait_i, in, 1: data memory not ready; the whole pipe freezes.
- branch_taken_i, in, 1: a taken branch or jump resolved in EX.
- stall_pc_o, out, 1: hold the PC.
- nop_o, out, 1: insert a bubble into ID/EX.
- nop_ex_o, out, 1: insert a bubble into EX/MEM.
- stall_r_o, out, N_REGS: per-register hold.
- flush_o, out, 1: squash IF/ID and ID/EX.
- busy_o, out, 1: state is not IDLE.

## Operation

- Load-use condition LU = MemRead_idr_i & (rd_idr_i != 0) & ((rs1_used_i & rd_idr_i == rs1_ifr_i) | (rs2_used_i & rd_idr_i == rs2_ifr_i)).
- States and the outputs they drive:
  - IDLE: no stall.
  - LU_STALL: stall_pc_o=1, nop_o=1, stall_r_o=...0001.
  - MD_BUSY: stall_pc_o=1, nop_ex_o=1, stall_r_o=...0011.
- The FREEZE pattern is stall_pc_o=1, stall_r_o all ones, every nop_o/flush_o=0.
- Per-cycle priority:
  1. mem_wait_i=1: FREEZE is output. State and counter hold. Any new detection is ignored and re-evaluated once the wait clears.
  2. State LU_STALL or MD_BUSY: that state's pattern is output and the counter decrements. When counter==0 this cycle, the next state is IDLE.
  3. IDLE with branch_taken_i=1: flush_o=1 for that cycle only. No stall starts, even if LU or md_start is also true.
  4. IDLE with md_start_idr_i=1: the MD_BUSY pattern is output this cycle. If MD_LAT>2, move to MD_BUSY with counter=MD_LAT-3.
  5. IDLE with LU=1: the LU_STALL pattern is output this cycle. If LOAD_LAT>1, move to LU_STALL with counter=LOAD_LAT-2.
  6. Otherwise all outputs are 0.
- md_start wins over LU in the same cycle; a mul/div in ID/EX never has MemRead set.
- In a stall state, the ID/EX inputs are bubbles; detection is not re-run until the state returns to IDLE.
- The counter is 4 bits wide and unsigned; it never wraps because exit happens at 0.

## Timing

- Outputs are Mealy: they are combinational from the registered state and the current inputs, with no input-to-state latency for the first stall cycle.
- A load-use stall lasts exactly LOAD_LAT cycles, counted from the detection cycle.
- A mul/div stall lasts exactly MD_LAT-1 cycles, counted from the md_start cycle.
- Cycles with mem_wait_i=1 extend either stall 1:1.
- Reset (asynchronous assert, synchronous release) puts the block in state IDLE with counter=0.
- Outputs during and after reset: stall_pc_o=0, nop_o=0, nop_ex_o=0, stall_r_o=0, flush_o=0, busy_o=0.
- Reset asserted mid-stall aborts the stall immediately.
- busy_o=1 in every cycle in which the registered state is LU_STALL or MD_BUSY.

## Test plan

- LOAD_LAT=1, rd=5, rs1=5, rs1_used=1, MemRead=1 → exactly 1 cycle with stall_pc_o=1, nop_o=1, stall_r_o=0001, busy_o stays 0. Repeat with rs1_used=0 → no stall. Repeat with rd=0 → no stall.
- LOAD_LAT=3, rd=7, rs2=7, rs2_used=1 → stall pattern for cycles 0,1,2; busy_o=1 in cycles 1,2; IDLE in cycle 3.
- MD_LAT=4, md_start_idr_i pulsed once → 3 cycles of stall_pc_o=1, nop_ex_o=1, stall_r_o=0011; then all outputs 0.
- LOAD_LAT=3, mem_wait_i=1 for 2 cycles starting at stall cycle 1 → FREEZE (stall_r_o=1111) for 2 cycles, then 2 more LU cycles; total stall span is 5 cycles.
- IDLE, branch_taken_i=1 together with LU=1 → flush_o=1 for one cycle, nop_o=0, no stall in the next cycle.
- MD_LAT=8, rst_ni pulled low in MD_BUSY cycle 2 → all outputs 0 in the same cycle, busy_o=0. After release, a fresh load-use event behaves as in the first scenario.
